draw_quad: RTL and testbench

- Responder side of the quad-drawing handshake used by the screen renderer.
- Accepts four vertices with a `start` pulse and rasterises a filled quad with vertical left and right edges (a pseudo-3D wall or floor face).
- Emits one pixel coordinate per cycle, plus `busy` and a one-cycle `done`.
- Sits between the screen-drawing FSM and the framebuffer write port.

---
 rtl/draw_pkg.sv | 15 +
 rtl/draw_edge_step.sv | 74 +++++++
 rtl/draw_quad.sv | 185 ++++++++++++++++++
 tb/tb_draw_quad.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared state encoding and default coordinate width for the quad rasteriser.
package draw_pkg;

  localparam int CORDW_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SPAN,
    ADV,
    STEP,
    DONE
  } quad_state_t;

endpackage

// File: rtl/draw_edge_step.sv
// Bresenham stepper for one quad edge: accumulates |dy| per column and steps y
// by its sign once per cycle while the error term has room for another dx.
module draw_edge_step import draw_pkg::*; #(
  parameter int CORDW = CORDW_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init,
  input  logic                    adv,
  input  logic                    step,
  input  logic        [CORDW-1:0] dx,
  input  logic signed [CORDW:0]   dy,
  input  logic signed [CORDW-1:0] y_start,
  output logic signed [CORDW-1:0] y,
  output logic signed [CORDW-1:0] y_next,
  output logic                    need_step,
  output logic                    need_next
);

  localparam int EW = CORDW + 2;
  localparam logic signed [CORDW-1:0] One = CORDW'(1);

  logic        [EW-1:0]    err_q, err_d;
  logic        [EW-1:0]    dx_ext, dy_ext;
  logic        [CORDW-1:0] dy_abs_q, dy_abs_d;
  logic                    neg_q, neg_d;
  logic signed [CORDW-1:0] y_q, y_d;
  logic        [CORDW:0]   dy_mag;
  logic                    unused_dy_msb;

  // |dy| never exceeds 2^CORDW-1, so the magnitude's top bit is always clear.
  assign dy_mag        = dy[CORDW] ? $unsigned(-dy) : $unsigned(dy);
  assign unused_dy_msb = dy_mag[CORDW];
  assign dx_ext        = {2'b00, dx};
  assign dy_ext        = {2'b00, dy_abs_q};

  always_comb begin
    err_d    = err_q;
    y_d      = y_q;
    dy_abs_d = dy_abs_q;
    neg_d    = neg_q;
    if (init) begin
      err_d    = '0;
      y_d      = y_start;
      dy_abs_d = dy_mag[CORDW-1:0];
      neg_d    = dy[CORDW];
    end else if (adv) begin
      err_d = err_q + dy_ext;
    end else if (step) begin
      err_d = err_q - dx_ext;
      y_d   = neg_q ? y_q - One : y_q + One;
    end
  end

  assign y         = y_q;
  assign y_next    = y_d;
  assign need_step = (err_q >= dx_ext);
  assign need_next = (err_d >= dx_ext);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q    <= '0;
      y_q      <= '0;
      dy_abs_q <= '0;
      neg_q    <= 1'b0;
    end else begin
      err_q    <= err_d;
      y_q      <= y_d;
      dy_abs_q <= dy_abs_d;
      neg_q    <= neg_d;
    end
  end

endmodule

// File: rtl/draw_quad.sv
// Rasterises a filled quad with vertical left/right edges, one pixel per cycle,
// column by column in ascending x and ascending y within each column.
module draw_quad import draw_pkg::*; #(
  parameter int CORDW = CORDW_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    oe,
  input  logic signed [CORDW-1:0] x0,
  input  logic signed [CORDW-1:0] y0,
  input  logic signed [CORDW-1:0] x1,
  input  logic signed [CORDW-1:0] y1,
  input  logic signed [CORDW-1:0] x2,
  input  logic signed [CORDW-1:0] y2,
  input  logic signed [CORDW-1:0] x3,
  input  logic signed [CORDW-1:0] y3,
  output logic signed [CORDW-1:0] x,
  output logic signed [CORDW-1:0] y,
  output logic                    drawing,
  output logic                    busy,
  output logic                    done
);

  localparam logic signed [CORDW-1:0] One = CORDW'(1);

  quad_state_t state_q, state_d;

  logic signed [CORDW-1:0] lx0_q, lx0_d, ly0_q, ly0_d, lx1_q, lx1_d, ly1_q, ly1_d;
  logic signed [CORDW-1:0] ly2_q, ly2_d, ly3_q, ly3_d;
  logic signed [CORDW-1:0] col_q, col_d, xend_q, xend_d, cur_y_q, cur_y_d;
  logic        [CORDW-1:0] dx_q, dx_d;

  logic                    swap;
  logic signed [CORDW-1:0] xl, xr, ytl, ytr, ybl, ybr;
  logic        [CORDW-1:0] dx_n;
  logic signed [CORDW:0]   dy_t, dy_b;

  logic signed [CORDW-1:0] yt, yb, yt_next, yb_next, span_max;
  logic                    need_t, need_b, need_next_t, need_next_b;
  logic                    unused_x;

  assign unused_x = ^{x2, x3};

  // Normalise so the left column is always the lower x; the pixel set is unchanged.
  assign swap = (lx1_q < lx0_q);
  assign xl   = swap ? lx1_q : lx0_q;
  assign xr   = swap ? lx0_q : lx1_q;
  assign ytl  = swap ? ly1_q : ly0_q;
  assign ytr  = swap ? ly0_q : ly1_q;
  assign ybl  = swap ? ly2_q : ly3_q;
  assign ybr  = swap ? ly3_q : ly2_q;
  assign dx_n = xr - xl;
  assign dy_t = {ytr[CORDW-1], ytr} - {ytl[CORDW-1], ytl};
  assign dy_b = {ybr[CORDW-1], ybr} - {ybl[CORDW-1], ybl};

  draw_edge_step #(.CORDW(CORDW)) u_top (
    .clk       (clk),
    .rst       (rst),
    .init      (state_q == INIT),
    .adv       (state_q == ADV),
    .step      ((state_q == STEP) && need_t),
    .dx        (dx_q),
    .dy        (dy_t),
    .y_start   (ytl),
    .y         (yt),
    .y_next    (yt_next),
    .need_step (need_t),
    .need_next (need_next_t)
  );

  draw_edge_step #(.CORDW(CORDW)) u_bot (
    .clk       (clk),
    .rst       (rst),
    .init      (state_q == INIT),
    .adv       (state_q == ADV),
    .step      ((state_q == STEP) && need_b),
    .dx        (dx_q),
    .dy        (dy_b),
    .y_start   (ybl),
    .y         (yb),
    .y_next    (yb_next),
    .need_step (need_b),
    .need_next (need_next_b)
  );

  assign span_max = (yt > yb) ? yt : yb;

  always_comb begin
    state_d = state_q;
    lx0_d   = lx0_q;
    ly0_d   = ly0_q;
    lx1_d   = lx1_q;
    ly1_d   = ly1_q;
    ly2_d   = ly2_q;
    ly3_d   = ly3_q;
    col_d   = col_q;
    xend_d  = xend_q;
    cur_y_d = cur_y_q;
    dx_d    = dx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          lx0_d   = x0;
          ly0_d   = y0;
          lx1_d   = x1;
          ly1_d   = y1;
          ly2_d   = y2;
          ly3_d   = y3;
          state_d = INIT;
        end
      end
      INIT: begin
        col_d   = xl;
        xend_d  = xr;
        dx_d    = dx_n;
        cur_y_d = (ytl < ybl) ? ytl : ybl;
        state_d = SPAN;
      end
      SPAN: begin
        if (oe) begin
          if (cur_y_q < span_max) begin
            cur_y_d = cur_y_q + One;
          end else if (col_q < xend_q) begin
            state_d = ADV;
          end else begin
            state_d = DONE;
          end
        end
      end
      ADV: begin
        col_d   = col_q + One;
        state_d = STEP;
      end
      STEP: begin
        // Leave as soon as this cycle's steps settle both edges for the column.
        if (!(need_next_t || need_next_b)) begin
          cur_y_d = (yt_next < yb_next) ? yt_next : yb_next;
          state_d = SPAN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lx0_q   <= '0;
      ly0_q   <= '0;
      lx1_q   <= '0;
      ly1_q   <= '0;
      ly2_q   <= '0;
      ly3_q   <= '0;
      col_q   <= '0;
      xend_q  <= '0;
      cur_y_q <= '0;
      dx_q    <= '0;
    end else begin
      state_q <= state_d;
      lx0_q   <= lx0_d;
      ly0_q   <= ly0_d;
      lx1_q   <= lx1_d;
      ly1_q   <= ly1_d;
      ly2_q   <= ly2_d;
      ly3_q   <= ly3_d;
      col_q   <= col_d;
      xend_q  <= xend_d;
      cur_y_q <= cur_y_d;
      dx_q    <= dx_d;
    end
  end

  assign drawing = (state_q == SPAN) && oe;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign x       = (state_q == SPAN) ? col_q : '0;
  assign y       = (state_q == SPAN) ? cur_y_q : '0;

endmodule

// File: tb/tb_draw_quad.sv
// Bench for draw_quad: a pixel-list model predicts every cycle's outputs from the
// vertex geometry, and directed quads pin exact timings with literal values.
module tb_draw_quad;

  localparam int CW = 16;
  localparam int MIdle = 0, MGap = 1, MSpan = 2, MDone = 3;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, oe = 1'b1;
  logic signed [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic signed [CW-1:0] x2 = '0, y2 = '0, x3 = '0, y3 = '0;
  logic signed [CW-1:0] x, y;
  logic drawing, busy, done;

  draw_quad #(.CORDW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .oe      (oe),
    .x0      (x0),
    .y0      (y0),
    .x1      (x1),
    .y1      (y1),
    .x2      (x2),
    .y2      (y2),
    .x3      (x3),
    .y3      (y3),
    .x       (x),
    .y       (y),
    .drawing (drawing),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct { int px; int py; bit col_end; int gap; } px_t;
  typedef struct { int c; int px; int py; } ev_t;

  int   vectors = 0, miscompares = 0;
  int   cyc = 0;
  int   done_cyc = -1;
  int   mphase = MIdle, gap_cnt = 0;
  px_t  exp_q[$];
  ev_t  log_q[$];
  ev_t  save_q[$];
  int   r_off[6] = '{2, 3, 6, 7, 10, 11};
  int   r_x[6]   = '{0, 0, 1, 1, 2, 2};
  int   r_y[6]   = '{0, 1, 0, 1, 0, 1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // y of an edge at column k: start + sgn(d) * floor(|d| * k / dx).
  function automatic int edge_y(input int ya, input int yb, input int dx, input int k);
    int d;
    if (dx == 0) return ya;
    d = yb - ya;
    if (d < 0) return ya - ((-d) * k) / dx;
    return ya + (d * k) / dx;
  endfunction

  // Expected pixel list; gap = idle cycles before the next column's first pixel.
  task automatic build(input int ax0, ay0, ax1, ay1, ay2, ay3);
    int  l, dx, ytl, ytr, ybl, ybr;
    bit  sw;
    px_t p;
    sw  = (ax1 < ax0);
    l   = sw ? ax1 : ax0;
    dx  = sw ? ax0 - ax1 : ax1 - ax0;
    ytl = sw ? ay1 : ay0;
    ytr = sw ? ay0 : ay1;
    ybl = sw ? ay2 : ay3;
    ybr = sw ? ay3 : ay2;
    exp_q.delete();
    for (int k = 0; k <= dx; k++) begin
      int yt, yb, lo, hi, st, sb;
      yt = edge_y(ytl, ytr, dx, k);
      yb = edge_y(ybl, ybr, dx, k);
      lo = (yt < yb) ? yt : yb;
      hi = (yt < yb) ? yb : yt;
      st = 0;
      sb = 0;
      if (k < dx) begin
        st = iabs(edge_y(ytl, ytr, dx, k + 1) - yt);
        sb = iabs(edge_y(ybl, ybr, dx, k + 1) - yb);
      end
      for (int yy = lo; yy <= hi; yy++) begin
        p.px      = l + k;
        p.py      = yy;
        p.col_end = (yy == hi);
        p.gap     = (k < dx) ? 1 + imax(1, imax(st, sb)) : 0;
        exp_q.push_back(p);
      end
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    px_t p;
    if (drawing) begin
      e.c  = cyc;
      e.px = int'(x);
      e.py = int'(y);
      log_q.push_back(e);
    end
    if (done) done_cyc = cyc;
    if (rst) begin
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_drawing", drawing, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      mphase = MIdle;
      exp_q.delete();
    end else begin
      case (mphase)
        MIdle: begin
          chk("idle_busy", busy, 0);
          chk("idle_drawing", drawing, 0);
          chk("idle_done", done, 0);
          if (start) begin
            build(int'(x0), int'(y0), int'(x1), int'(y1), int'(y2), int'(y3));
            gap_cnt = 1;
            mphase  = MGap;
          end
        end
        MGap: begin
          chk("gap_busy", busy, 1);
          chk("gap_drawing", drawing, 0);
          chk("gap_done", done, 0);
          gap_cnt--;
          if (gap_cnt == 0) mphase = MSpan;
        end
        MSpan: begin
          chk("span_busy", busy, 1);
          chk("span_done", done, 0);
          chk("span_drawing", drawing, oe);
          if (oe && exp_q.size() > 0) begin
            p = exp_q.pop_front();
            chk("pix_x", x, p.px);
            chk("pix_y", y, p.py);
            if (p.col_end) begin
              if (p.gap == 0) begin
                mphase = MDone;
              end else begin
                gap_cnt = p.gap;
                mphase  = MGap;
              end
            end
          end
        end
        default: begin
          chk("done_busy", busy, 1);
          chk("done_drawing", drawing, 0);
          chk("done_pulse", done, 1);
          mphase = MIdle;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int ax0, ay0, ax1, ay1, ay2, ay3, output int t0);
    x0 = CW'(ax0);
    y0 = CW'(ay0);
    x1 = CW'(ax1);
    y1 = CW'(ay1);
    x2 = CW'(ax1);
    y2 = CW'(ay2);
    x3 = CW'(ax0);
    y3 = CW'(ay3);
    log_q.delete();
    done_cyc = -1;
    start    = 1'b1;
    t0       = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd);
    int n;
    n = 0;
    while (done_cyc < 0 && n < 4000) begin
      if (rnd) begin
        oe    = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 7) == 0);
        x0 = CW'($urandom);
        y0 = CW'($urandom);
        x1 = CW'($urandom);
        y1 = CW'($urandom);
        y2 = CW'($urandom);
        y3 = CW'($urandom);
      end
      tick();
      n++;
    end
    start = 1'b0;
    oe    = 1'b1;
    chk("draw_completes", done_cyc >= 0, 1);
  endtask

  task automatic check_rect(input int t, input int shift);
    chk("rect_count", log_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < log_q.size()) begin
        chk("rect_cycle", log_q[i].c - t, r_off[i] + shift);
        chk("rect_x", log_q[i].px, r_x[i]);
        chk("rect_y", log_q[i].py, r_y[i]);
      end
    end
    chk("rect_done_cycle", done_cyc - t, 12 + shift);
  endtask

  initial begin
    int t;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_x", x, 0);
    rst = 1'b0;
    tick();

    // Model pins: trapezoid pixel count and steep-edge column gap.
    build(0, 0, 4, 4, 6, 10);
    chk("model_trap_count", exp_q.size(), 35);
    build(0, 0, 1, 10, 10, 10);
    chk("model_steep_count", exp_q.size(), 12);
    if (exp_q.size() > 10) chk("model_steep_gap", exp_q[10].gap, 11);
    exp_q.delete();

    // Rectangle.
    launch(0, 0, 2, 0, 1, 1, t);
    wait_done(1'b0);
    check_rect(t, 0);
    tick();

    // Trapezoid, then mirrored vertex order.
    launch(0, 0, 4, 4, 6, 10, t);
    wait_done(1'b0);
    chk("trap_count", log_q.size(), 35);
    save_q = log_q;
    tick();
    launch(4, 4, 0, 0, 10, 6, t);
    wait_done(1'b0);
    chk("trap_swap_count", log_q.size(), 35);
    for (int i = 0; i < 35; i++) begin
      if (i < log_q.size() && i < save_q.size()) begin
        chk("trap_swap_x", log_q[i].px, save_q[i].px);
        chk("trap_swap_y", log_q[i].py, save_q[i].py);
      end
    end
    tick();

    // Degenerate single column.
    launch(5, 7, 5, 7, 3, 3, t);
    wait_done(1'b0);
    chk("dx0_count", log_q.size(), 5);
    if (log_q.size() == 5) begin
      chk("dx0_first_y", log_q[0].py, 3);
      chk("dx0_last_y", log_q[4].py, 7);
      chk("dx0_x", log_q[4].px, 5);
      chk("dx0_done_gap", done_cyc - log_q[4].c, 1);
    end
    tick();

    // Steep edge: ten STEP cycles before column 1.
    launch(0, 0, 1, 10, 10, 10, t);
    wait_done(1'b0);
    chk("steep_count", log_q.size(), 12);
    if (log_q.size() == 12) begin
      chk("steep_col1_cycle", log_q[11].c - t, 24);
      chk("steep_col1_x", log_q[11].px, 1);
      chk("steep_col1_y", log_q[11].py, 10);
    end
    chk("steep_done_cycle", done_cyc - t, 25);
    tick();

    // Rectangle with a 3-cycle output stall in the first span.
    launch(0, 0, 2, 0, 1, 1, t);
    tick();
    oe = 1'b0;
    repeat (3) tick();
    oe = 1'b1;
    wait_done(1'b0);
    check_rect(t, 3);
    tick();

    // Start while busy is ignored; reset mid-draw aborts with no done.
    launch(0, 0, 2, 0, 1, 1, t);
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_drawing", drawing, 0);
    chk("abort_done", done, 0);
    chk("abort_x", x, 0);
    chk("abort_y", y, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("abort_no_done", done_cyc, -1);
    launch(0, 0, 2, 0, 1, 1, t);
    wait_done(1'b0);
    check_rect(t, 0);
    tick();

    // Random quads with random stalls, stray starts and scrambled vertex inputs.
    for (int i = 0; i < 30; i++) begin
      launch($urandom_range(0, 18) - 9, $urandom_range(0, 18) - 9,
             $urandom_range(0, 18) - 9, $urandom_range(0, 18) - 9,
             $urandom_range(0, 18) - 9, $urandom_range(0, 18) - 9, t);
      wait_done(1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
